// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift window,
// border taps are replaced by PAD_VALUE from the registered centre position.
//
// state | meaning
// IDLE  | waiting for iStart
// RUN   | accepting raster pixels
// FLUSH | WIDTH+1 padded advances push out the trailing windows
// DONE  | holding the final window until downstream accepts it
module window3x3_linebuf #(
   parameter int DATA_W = 24,
   parameter int WIDTH = 480,
   parameter int HEIGHT = 272,
   parameter logic [DATA_W-1:0] PAD_VALUE = '0,
   localparam int COL_W = $clog2(WIDTH),
   localparam int ROW_W = $clog2(HEIGHT)
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iStart,
   input  logic                  iValid,
   output logic                  oReady,
   input  logic [DATA_W-1:0]     iPixel,
   output logic                  oValid,
   input  logic                  iReady,
   output logic [9*DATA_W-1:0]   oWindow,
   output logic [COL_W-1:0]      oCol,
   output logic [ROW_W-1:0]      oRow,
   output logic                  oBusy,
   output logic                  oDone
);

   localparam int FL_W = $clog2(WIDTH + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
   localparam logic [FL_W-1:0] FL_ONE = FL_W'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
   state_t state, stateNxt;

   logic [COL_W-1:0]  inCol, qCol;
   logic [ROW_W-1:0]  inRow, qRow;
   logic [FL_W-1:0]   flushCnt;
   logic              windowsOn;
   logic              slotFree, accept, advance, emit, lastPix, flushLast;
   logic [DATA_W-1:0] newPix;
   logic [DATA_W-1:0] lb1 [WIDTH];
   logic [DATA_W-1:0] lb2 [WIDTH];
   logic [DATA_W-1:0] rawWin [9];
   logic [DATA_W-1:0] winNxt [9];
   logic [9*DATA_W-1:0] winPad;
   logic              padTap;

   assign slotFree  = !oValid || iReady;
   assign accept    = iValid && oReady;
   assign advance   = accept || (state == FLUSH && slotFree);
   assign lastPix   = (inCol == COL_LAST) && (inRow == ROW_LAST);
   assign flushLast = (flushCnt == '0);
   // Centre index reaches zero once pixel (1,1) arrives.
   assign emit      = advance && (windowsOn || (state == RUN && inRow == ROW_ONE && inCol == COL_ONE));
   assign newPix    = (state == RUN) ? iPixel : PAD_VALUE;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) state <= IDLE;
      else       state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (iStart) stateNxt = RUN;
         RUN:     if (accept && lastPix) stateNxt = FLUSH;
         FLUSH:   if (slotFree && flushLast) stateNxt = DONE;
         DONE:    if (oValid && iReady) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_comb begin
      oReady = 1'b0;
      oBusy  = 1'b0;
      oDone  = 1'b0;
      case (state)
         RUN: begin
            oReady = slotFree;
            oBusy  = 1'b1;
         end
         FLUSH:   oBusy = 1'b1;
         DONE:    oDone = oValid && iReady;
         default: ;
      endcase
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         winNxt[r*3]     = rawWin[r*3+1];
         winNxt[r*3 + 1] = rawWin[r*3+2];
         winNxt[r*3 + 2] = rawWin[r*3+2];
      end
      winNxt[2] = lb2[inCol];
      winNxt[5] = lb1[inCol];
      winNxt[8] = newPix;
   end

   // Right-column taps at the last column hold the next line's start; they must be masked.
   always_comb begin
      winPad = '0;
      padTap = 1'b0;
      for (int k = 0; k < 9; k++) begin
         padTap = (k < 3 && qRow == '0) || (k >= 6 && qRow == ROW_LAST) ||
                  (k % 3 == 0 && qCol == '0) || (k % 3 == 2 && qCol == COL_LAST);
         winPad[k*DATA_W +: DATA_W] = padTap ? PAD_VALUE : winNxt[k];
      end
   end

   always_ff @(posedge iClk) begin
      if (advance) begin
         lb1[inCol] <= newPix;
         lb2[inCol] <= lb1[inCol];
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         inCol     <= '0;
         inRow     <= '0;
         qCol      <= '0;
         qRow      <= '0;
         flushCnt  <= '0;
         windowsOn <= 1'b0;
         oValid    <= 1'b0;
         oWindow   <= '0;
         oCol      <= '0;
         oRow      <= '0;
         for (int k = 0; k < 9; k++) rawWin[k] <= '0;
      end else begin
         if (advance) begin
            inCol <= (inCol == COL_LAST) ? '0 : inCol + COL_ONE;
            if (state == RUN && inCol == COL_LAST)
               inRow <= (inRow == ROW_LAST) ? '0 : inRow + ROW_ONE;
            for (int k = 0; k < 9; k++) rawWin[k] <= winNxt[k];
         end

         if (accept && lastPix)
            flushCnt <= FL_W'(WIDTH);
         else if (state == FLUSH && slotFree && !flushLast)
            flushCnt <= flushCnt - FL_ONE;

         if (emit) begin
            windowsOn <= 1'b1;
            oValid    <= 1'b1;
            oWindow   <= winPad;
            oCol      <= qCol;
            oRow      <= qRow;
            qCol      <= (qCol == COL_LAST) ? '0 : qCol + COL_ONE;
            if (qCol == COL_LAST)
               qRow <= (qRow == ROW_LAST) ? '0 : qRow + ROW_ONE;
         end else if (iReady) begin
            oValid <= 1'b0;
         end

         if (state == IDLE && iStart) begin
            inCol     <= '0;
            inRow     <= '0;
            qCol      <= '0;
            qRow      <= '0;
            windowsOn <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Bench for window3x3_linebuf: two 4x3 instances (pad 0 and pad FFFFFF) share
// stimulus; every accepted window is checked against a direct image model.
module tb_window3x3_linebuf;

   localparam int DW = 24;
   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;
   localparam int WB = 9 * DW;
   typedef logic [WB-1:0] wide_t;

   logic iClk = 1'b0;
   logic iRst = 1'b0;
   logic iStart = 1'b0;
   logic iValid = 1'b0;
   logic iReady = 1'b1;
   logic [DW-1:0] iPixel = '0;

   logic oReadyV [2];
   logic oValidV [2];
   logic oBusyV [2];
   logic oDoneV [2];
   wide_t oWindowV [2];
   logic [1:0] oColV [2];
   logic [1:0] oRowV [2];

   logic [DW-1:0] img [N];
   int nCmp = 0;
   int nErr = 0;
   int winIdx [2];
   int doneCnt [2];
   int acc [2];
   logic seenFirst [2];
   logic stallPrev [2];
   wide_t heldWin [2];
   logic [3:0] heldPos [2];
   logic litFrame = 1'b0;
   logic rndReady = 1'b0;

   always #5 iClk = ~iClk;

   window3x3_linebuf #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H), .PAD_VALUE(24'h000000)) dut0 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid), .oReady(oReadyV[0]),
      .iPixel(iPixel), .oValid(oValidV[0]), .iReady(iReady), .oWindow(oWindowV[0]),
      .oCol(oColV[0]), .oRow(oRowV[0]), .oBusy(oBusyV[0]), .oDone(oDoneV[0]));

   window3x3_linebuf #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H), .PAD_VALUE(24'hFFFFFF)) dut1 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid), .oReady(oReadyV[1]),
      .iPixel(iPixel), .oValid(oValidV[1]), .iReady(iReady), .oWindow(oWindowV[1]),
      .oCol(oColV[1]), .oRow(oRowV[1]), .oBusy(oBusyV[1]), .oDone(oDoneV[1]));

   function automatic logic [DW-1:0] padFor(input int d);
      return (d == 0) ? 24'h000000 : 24'hFFFFFF;
   endfunction

   // Window centred on raster index n, taken straight from the image.
   function automatic wide_t expWin(input int n, input logic [DW-1:0] pad);
      wide_t w;
      int r, c, rr, cc;
      w = '0;
      r = n / W;
      c = n % W;
      for (int k = 0; k < 9; k++) begin
         rr = r + k / 3 - 1;
         cc = c + k % 3 - 1;
         if (rr < 0 || rr >= H || cc < 0 || cc >= W) w[k*DW +: DW] = pad;
         else w[k*DW +: DW] = img[rr*W + cc];
      end
      return w;
   endfunction

   function automatic wide_t lit9(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7, input int a8);
      wide_t w;
      int t [9];
      t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      w = '0;
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(t[k]);
      return w;
   endfunction

   task automatic chk(input string nm, input int d, input wide_t act, input wide_t exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
      end
   endtask

   always @(negedge iClk) begin
      int n;
      if (!iRst) begin
         for (int d = 0; d < 2; d++) begin
            winIdx[d] = 0; doneCnt[d] = 0; acc[d] = 0;
            seenFirst[d] = 1'b0; stallPrev[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (iStart && !oBusyV[d]) begin
               winIdx[d] = 0; acc[d] = 0; seenFirst[d] = 1'b0;
            end
            if (stallPrev[d]) begin
               chk("stall_valid", d, wide_t'(oValidV[d]), wide_t'(1));
               chk("stall_window", d, oWindowV[d], heldWin[d]);
               chk("stall_pos", d, wide_t'({oRowV[d], oColV[d]}), wide_t'(heldPos[d]));
            end
            if (oValidV[d] && !seenFirst[d]) begin
               seenFirst[d] = 1'b1;
               chk("first_valid_pixels", d, wide_t'(acc[d]), wide_t'(W + 2));
            end
            if (oValidV[d] && iReady) begin
               n = winIdx[d];
               if (n >= N) begin
                  nCmp++; nErr++;
                  $display("FAIL extra_window dut%0d: got window number %0d expected at most %0d", d, n + 1, N);
               end else begin
                  chk("pos", d, wide_t'({oRowV[d], oColV[d]}), wide_t'({2'(n / W), 2'(n % W)}));
                  chk("window", d, oWindowV[d], expWin(n, padFor(d)));
                  if (d == 0 && litFrame) begin
                     case (n)
                        0:  chk("lit_w00", d, oWindowV[d], lit9(0, 0, 0, 0, 1, 2, 0, 5, 6));
                        5:  chk("lit_w11", d, oWindowV[d], lit9(1, 2, 3, 5, 6, 7, 9, 10, 11));
                        7:  chk("lit_w13", d, oWindowV[d], lit9(3, 4, 0, 7, 8, 0, 11, 12, 0));
                        11: chk("lit_w23", d, oWindowV[d], lit9(7, 8, 0, 11, 12, 0, 0, 0, 0));
                        default: ;
                     endcase
                  end
               end
               winIdx[d]++;
            end
            stallPrev[d] = oValidV[d] && !iReady;
            heldWin[d] = oWindowV[d];
            heldPos[d] = {oRowV[d], oColV[d]};
            if (stallPrev[d]) chk("stall_ready", d, wide_t'(oReadyV[d]), wide_t'(0));
            if (!oBusyV[d]) chk("idle_ready", d, wide_t'(oReadyV[d]), wide_t'(0));
            if (iValid && oReadyV[d]) acc[d]++;
            if (oDoneV[d]) begin
               chk("done_windows", d, wide_t'(winIdx[d]), wide_t'(N));
               doneCnt[d]++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge iClk);
      #1;
      if (rndReady) iReady = ($urandom_range(0, 3) != 0);
   endtask

   task automatic sendPix(input logic [DW-1:0] px, input logic gaps);
      int t;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      iPixel = px;
      iValid = 1'b1;
      t = 0;
      while (1) begin
         @(negedge iClk);
         if (oReadyV[0]) break;
         if (t >= 200) begin
            nCmp++; nErr++;
            $display("FAIL accept_timeout: pixel %h still not accepted after %0d cycles, required acceptance", px, t);
            break;
         end
         tick();
         t++;
      end
      tick();
      iValid = 1'b0;
   endtask

   task automatic runFrame(input logic gaps, input logic stall, input logic midStart, input logic flushChk);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (midStart && i == 3) iStart = 1'b1;
         if (stall && i == 8) begin
            iReady = 1'b0;
            iPixel = img[i];
            iValid = 1'b1;
            repeat (3) tick();
            iReady = 1'b1;
         end
         sendPix(img[i], gaps);
         iStart = 1'b0;
      end
      if (flushChk) chk("flush_windows", 0, wide_t'(N - winIdx[0] - 1), wide_t'(5));
   endtask

   task automatic waitDone();
      int b0, b1, t;
      b0 = doneCnt[0];
      b1 = doneCnt[1];
      t = 0;
      while (!(doneCnt[0] > b0 && doneCnt[1] > b1) && t < 200) begin
         tick();
         t++;
      end
      chk("done_pulses", 0, wide_t'(doneCnt[0] - b0), wide_t'(1));
      chk("done_pulses", 1, wide_t'(doneCnt[1] - b1), wide_t'(1));
      for (int d = 0; d < 2; d++) begin
         chk("frame_windows", d, wide_t'(winIdx[d]), wide_t'(N));
         chk("back_to_idle", d, wide_t'(oBusyV[d]), wide_t'(0));
      end
   endtask

   task automatic checkReset();
      @(negedge iClk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_flags", d,
             wide_t'({oValidV[d], oReadyV[d], oBusyV[d], oDoneV[d], oRowV[d], oColV[d]}), wide_t'(0));
         chk("reset_window", d, oWindowV[d], wide_t'(0));
      end
   endtask

   initial begin
      repeat (2) @(posedge iClk);
      checkReset();
      tick();
      iRst = 1'b1;
      tick();

      for (int i = 0; i < N; i++) img[i] = DW'(i + 1);
      litFrame = 1'b1;
      runFrame(1'b0, 1'b0, 1'b0, 1'b1);
      waitDone();
      runFrame(1'b0, 1'b1, 1'b1, 1'b0);
      waitDone();
      litFrame = 1'b0;

      iPixel = 24'hABCDEF;
      iValid = 1'b1;
      repeat (3) tick();
      iValid = 1'b0;

      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      rndReady = 1'b1;
      runFrame(1'b1, 1'b0, 1'b0, 1'b0);
      waitDone();
      rndReady = 1'b0;
      iReady = 1'b1;
      tick();

      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int i = 0; i < 7; i++) sendPix(img[i], 1'b0);
      iRst = 1'b0;
      checkReset();
      tick();
      tick();
      iRst = 1'b1;
      tick();

      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      runFrame(1'b0, 1'b0, 1'b0, 1'b0);
      waitDone();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule

// File: doc/window3x3_linebuf.md
Name: window3x3_linebuf

Overview:
Streaming 3x3 neighbourhood generator for the CNN front end. It replaces BRAM re-fetch windowing with two on-chip line buffers. It accepts one raster-order pixel per handshake and emits one 3x3 window per image pixel, centred on that pixel, with constant padding at the borders. It sits between the pixel source (frame BRAM reader or camera stream) and the MAC/conv stage, and honours the MAC's backpressure.

Parameters:
DATA_W, 24, bits per pixel (RGB888 packed).
WIDTH, 480, pixels per line; must be >= 3.
HEIGHT, 272, lines per frame; must be >= 2.
PAD_VALUE, 0, DATA_W-bit constant substituted for out-of-frame taps.

Ports:
iClk  in  1  clock.
iRst  in  1  asynchronous, active-low reset.
iStart  in  1  one-cycle pulse; starts a frame; honoured only in IDLE.
iValid  in  1  input pixel valid.
oReady  out  1  block can accept a pixel this cycle.
iPixel  in  DATA_W  input pixel, raster order.
oValid  out  1  oWindow holds a valid window.
iReady  in  1  downstream accepts the window (MAC not busy).
oWindow  out  9*DATA_W  taps, row-major; tap k = bits [k*DATA_W +: DATA_W]; tap0=(r-1,c-1), tap4=centre (r,c), tap8=(r+1,c+1).
oCol  out  clog2(WIDTH)  centre column of the current window.
oRow  out  clog2(HEIGHT)  centre row of the current window.
oBusy  out  1  high in RUN or FLUSH.
oDone  out  1  one-cycle pulse when the last window of the frame is accepted downstream.

Behaviour:
- Reset: state=IDLE; oValid, oReady, oBusy, oDone=0; oWindow, oCol, oRow=0; all counters=0. Line-buffer contents are don't-care.
- FSM states:
  - IDLE -> RUN on iStart. iStart is ignored in every other state.
  - RUN: accept pixels. Input index p counts 0..WIDTH*HEIGHT-1. Go to FLUSH after accepting p=WIDTH*HEIGHT-1.
  - FLUSH: WIDTH+1 advance steps with no input. Each step injects PAD_VALUE as the new bottom-row pixel. Go to DONE after the last step.
  - DONE: stay until the final window is accepted downstream, pulse oDone, then return to IDLE.
- Output stage (single register): slot_free = !oValid || iReady.
- oReady = (state==RUN) && slot_free. A pixel is accepted when iValid && oReady.
- Advance event: accepted pixel in RUN, or slot_free in FLUSH.
- On each advance:
  - Line buffers are read at the input column, then written: LB1[c] <= pixel, LB2[c] <= old LB1[c]. Reads are read-before-write, same cycle.
  - The 3x3 shift window shifts left one column. The new right column is {LB2 old, LB1 old, pixel}, top to bottom.
- Centre index q = p - (WIDTH+1). A window is emitted on every advance with q >= 0.
  - oWindow, oCol, oRow and oValid are registered on that advance: 1-cycle latency from the accepting edge.
  - The first oValid follows acceptance of pixel WIDTH+1.
  - Exactly WIDTH*HEIGHT windows are emitted per frame.
- Padding is applied in the output mux from the centre (r,c):
  - r==0: top row taps = PAD_VALUE.
  - r==HEIGHT-1: bottom row taps = PAD_VALUE.
  - c==0: left column taps = PAD_VALUE.
  - c==WIDTH-1: right column taps = PAD_VALUE. These taps hold wrapped next-line data, which must not leak.
- Backpressure: while oValid && !iReady, oWindow, oCol, oRow and oValid hold stable. oReady=0, no advance occurs, and no FLUSH step occurs.
- oValid drops the cycle after acceptance unless a new advance occurs in that same cycle.
- Counters: column counters wrap WIDTH-1 -> 0 and increment the row counter. The row counter wraps HEIGHT-1 -> 0 at end of frame.
- iValid while in IDLE, FLUSH or DONE is ignored (oReady=0).
- Reset asserted mid-frame: immediate return to the reset values above. The next frame behaves identically to the first.
- Back-to-back frames: iStart is accepted in the cycle after the oDone pulse. No stale line-buffer data may reach an output, which padding guarantees.

Test Plan:
- WIDTH=4, HEIGHT=3, pixels 1..12, iReady=1 -> first oValid one cycle after the 6th pixel is accepted. Window (0,0) = {0,0,0, 0,1,2, 0,5,6}.
- Same frame -> window (1,1) = {1,2,3, 5,6,7, 9,10,11}. Window (1,3) = {3,4,0, 7,8,0, 11,12,0}. Window (2,3) = {7,8,0, 11,12,0, 0,0,0}.
- Same frame -> exactly 12 windows with (oRow,oCol) in raster order. Five windows come out after the last input during FLUSH. oDone pulses once and the block returns to IDLE.
- iReady held low 3 cycles mid-frame with iValid=1 -> oWindow/oCol/oRow stable, oReady=0, no pixel lost. Sequence identical to the unstalled run.
- PAD_VALUE=24'hFFFFFF, random iValid gaps -> border taps = FFFFFF, interior taps match the golden model.
- iRst pulsed after 7 pixels, then a full frame -> outputs at reset values, then a correct full frame with 12 windows and one oDone.
